spi3w_target: RTL and testbench
===============================

Name: spi3w_target

Overview:
- 3-wire SPI target (responder) with a single bidirectional SDIO line, emulating a gyro-style register slave for loopback testing of the SPI master IP.
- Drives the shared pad through an external tristate I/O buffer:
  - sdio_o feeds the buffer data input.
  - sdio_t feeds the buffer enable; 1 = high-Z.
  - The buffer output returns as sdio_i.
- Holds an NREGS x 8 register file, readable and writable from SPI and from fabric.

Parameters:
- NREGS, 16, number of 8-bit registers; valid addresses are 0..NREGS-1.
- ADDR_W, 7, SPI address field width (fixed frame format: 1 R/W + 7 addr + 8 data).
- SYNC_STAGES, 2, synchronizer depth on sclk_in, csn_in and sdio_i.

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency.
- reset  in  1  synchronous, active-high reset.
- sclk_in  in  1  SPI clock from master, asynchronous, mode 0 (CPOL=0, CPHA=0).
- csn_in  in  1  chip select, active low, asynchronous.
- sdio_i  in  1  pad value from tristate buffer output.
- sdio_o  out  1  data to tristate buffer input.
- sdio_t  out  1  tristate control; 1 = release pad, 0 = drive sdio_o.
- host_we  in  1  fabric register write strobe.
- host_addr  in  $clog2(NREGS)  fabric register address (read and write).
- host_wdata  in  8  fabric write data.
- host_rdata  out  8  combinational read of regs[host_addr].
- spi_wr_stb  out  1  one-cycle pulse on each completed SPI write.
- spi_wr_addr  out  ADDR_W  address of last SPI write.
- spi_wr_data  out  8  data of last SPI write.
- frame_done  out  1  one-cycle pulse on each completed 16-bit frame.
- frame_err  out  1  one-cycle pulse on an aborted or out-of-range frame.

Behaviour:
- **Reset values:** all registers 0x00, sdio_t=1, sdio_o=0, all strobes 0, spi_wr_addr/data 0, state IDLE, armed=0.
- **Input conditioning:** sclk/csn/sdio each pass through SYNC_STAGES flops. Rise/fall are detected from the last two synced samples. Edge-to-action latency is SYNC_STAGES+1 clk.
- **Arming:** after reset the block leaves IDLE only after csn has been seen high (armed=1). This covers reset during an active frame.
- **Frame format:** bits are MSB first and sampled on SCLK rise.
  - Bit 0 is R/W (1 = read).
  - Bits 1-7 are the address.
  - Bits 8-15 are data.
- **States:**
  - IDLE: csn falls and armed → CMD, bitcnt=0.
  - CMD: shift sdio_i on each sclk rise. On the 8th rise, go to WDATA if R/W=0, else to RDATA.
    - Entering RDATA loads shift_tx from regs[addr], or 0x00 if addr ≥ NREGS.
  - WDATA: shift 8 bits. On the 16th rise → END.
    - If addr < NREGS: write the register, pulse spi_wr_stb, update spi_wr_addr/data, pulse frame_done.
    - Else: pulse frame_err and drop the write.
  - RDATA: on each sclk fall, sdio_t=0 and sdio_o = shift_tx[7]; then shift left. The first fall after the 8th rise drives bit 7. On the 16th rise → END.
    - Pulse frame_done if addr < NREGS, else frame_err (data still 0x00).
  - END: sdio_t=1 on entry. Ignore further SCLK edges; csn high → IDLE.
- **Abort:** csn rising in CMD, WDATA or RDATA:
  - sdio_t=1 within SYNC_STAGES+1 clk.
  - frame_err pulses once.
  - No register write; → IDLE.
- **csn high in any state** forces sdio_t=1.
- **Simultaneous host_we and SPI write to the same address in the same clk:** the SPI write wins. Different addresses both commit.
- **Read data snapshot:** read data is snapshotted at the RDATA transition; later host writes do not alter the in-flight byte.

Decomposition:
- Package spi3w_pkg:
  - state enum (IDLE, CMD, WDATA, RDATA, END).
  - FRAME_BITS=16, CMD_BITS=8, RW_READ=1'b1.
- Sub-module spi3w_sync: a SYNC_STAGES synchronizer plus rise/fall detector, instantiated three times.

Test Plan:
- **Write then read:** SPI write addr 0x03 data 0xA5, then SPI read addr 0x03.
  - spi_wr_stb once with addr 0x03 / data 0xA5.
  - Read returns 0xA5 MSB first.
  - host_rdata(3)=0xA5.
- **Turnaround timing:** read addr 0x00 after host writes 0x81.
  - sdio_t=1 through the 8th rise; it goes 0 within 3 clk of the following fall with sdio_o=1.
  - Bit stream 1000_0001; sdio_t=1 after the 16th rise.
- **Out-of-range:**
  - Write to addr 0x20 with NREGS=16: frame_err pulses once, no spi_wr_stb, registers unchanged.
  - Read of 0x20 returns 0x00 and frame_err pulses.
- **Abort:** csn raised after 11 SCLKs of a read of 0x05.
  - sdio_t=1 within 3 clk; frame_err pulses once; no frame_done.
  - The next full read of 0x05 is correct.
- **Collision:** host_we addr 2 data 0x11 in the same clk as an SPI write addr 2 data 0x22 → regs[2]=0x22.
- **Reset mid-frame:** assert reset during WDATA bit 12.
  - Outputs at reset values.
  - Remaining SCLKs of that frame ignored until csn goes high.
  - The next frame works normally.

Source files
------------

// File: rtl/spi3w_pkg.sv
// Shared types and frame constants for the 3-wire SPI target.
package spi3w_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        END
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/spi3w_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synced value.
module spi3w_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi3w_target.sv
// 3-wire SPI register target: 1 R/W + 7 addr + 8 data, mode 0, shared SDIO.
module spi3w_target
    import spi3w_pkg::*;
#(
    parameter int NREGS       = 16,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk_in,
    input  logic                     csn_in,
    input  logic                     sdio_i,
    output logic                     sdio_o,
    output logic                     sdio_t,
    input  logic                     host_we,
    input  logic [$clog2(NREGS)-1:0] host_addr,
    input  logic [7:0]               host_wdata,
    output logic [7:0]               host_rdata,
    output logic                     spi_wr_stb,
    output logic [ADDR_W-1:0]        spi_wr_addr,
    output logic [7:0]               spi_wr_data,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam int AW = $clog2(NREGS);

    logic sclk_q, sclk_rise, sclk_fall;
    logic csn_q, csn_rise, csn_fall;
    logic sdio_q, sdio_rise, sdio_fall;
    logic unused_edges;

    spi3w_sync #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .d(sclk_in),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi3w_sync #(.STAGES(SYNC_STAGES)) u_csn (
        .clk(clk), .reset(reset), .d(csn_in),
        .q(csn_q), .rise(csn_rise), .fall(csn_fall)
    );
    spi3w_sync #(.STAGES(SYNC_STAGES)) u_sdio (
        .clk(clk), .reset(reset), .d(sdio_i),
        .q(sdio_q), .rise(sdio_rise), .fall(sdio_fall)
    );

    assign unused_edges = ^{sclk_q, sdio_rise, sdio_fall};

    logic [7:0]        regs [NREGS];
    state_t            state, state_n;
    logic              armed, armed_n;
    logic [4:0]        bitcnt, bitcnt_n;
    logic [6:0]        shift_rx, shift_rx_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        shift_tx, shift_tx_n;
    logic              sdio_o_n, sdio_t_n;
    logic              stb_n, done_n, err_n;
    logic [ADDR_W-1:0] wr_addr_n;
    logic [7:0]        wr_data_n;
    logic              reg_we;
    logic [7:0]        rx_byte;
    logic              in_range, cmd_in_range;

    assign rx_byte      = {shift_rx, sdio_q};
    assign in_range     = 32'(addr) < NREGS;
    assign cmd_in_range = 32'(rx_byte[ADDR_W-1:0]) < NREGS;
    assign host_rdata   = regs[host_addr];

    always_comb begin
        state_n    = state;
        armed_n    = armed | csn_q;
        bitcnt_n   = bitcnt;
        shift_rx_n = shift_rx;
        addr_n     = addr;
        shift_tx_n = shift_tx;
        sdio_o_n   = sdio_o;
        sdio_t_n   = sdio_t;
        stb_n      = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        wr_addr_n  = spi_wr_addr;
        wr_data_n  = spi_wr_data;
        reg_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (csn_fall && armed) begin
                    state_n  = CMD;
                    bitcnt_n = '0;
                end
            end
            CMD: begin
                if (csn_rise) begin
                    state_n  = IDLE;
                    err_n    = 1'b1;
                    sdio_t_n = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx_n = rx_byte[6:0];
                    bitcnt_n   = bitcnt + 5'd1;
                    if (bitcnt == 5'(CMD_BITS - 1)) begin
                        addr_n = rx_byte[ADDR_W-1:0];
                        if (rx_byte[CMD_BITS-1] == RW_READ) begin
                            state_n    = RDATA;
                            // snapshot now so later host writes can't tear the byte
                            shift_tx_n = cmd_in_range ? regs[rx_byte[AW-1:0]] : 8'h00;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (csn_rise) begin
                    state_n  = IDLE;
                    err_n    = 1'b1;
                    sdio_t_n = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx_n = rx_byte[6:0];
                    bitcnt_n   = bitcnt + 5'd1;
                    if (bitcnt == 5'(FRAME_BITS - 1)) begin
                        state_n = END;
                        if (in_range) begin
                            reg_we    = 1'b1;
                            stb_n     = 1'b1;
                            done_n    = 1'b1;
                            wr_addr_n = addr;
                            wr_data_n = rx_byte;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            RDATA: begin
                if (csn_rise) begin
                    state_n  = IDLE;
                    err_n    = 1'b1;
                    sdio_t_n = 1'b1;
                end else if (sclk_fall) begin
                    sdio_t_n   = 1'b0;
                    sdio_o_n   = shift_tx[7];
                    shift_tx_n = {shift_tx[6:0], 1'b0};
                end else if (sclk_rise) begin
                    bitcnt_n = bitcnt + 5'd1;
                    if (bitcnt == 5'(FRAME_BITS - 1)) begin
                        state_n  = END;
                        sdio_t_n = 1'b1;
                        done_n   = in_range;
                        err_n    = ~in_range;
                    end
                end
            end
            END: begin
                sdio_t_n = 1'b1;
                if (csn_q) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (csn_q) sdio_t_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            bitcnt      <= '0;
            shift_rx    <= '0;
            addr        <= '0;
            shift_tx    <= '0;
            sdio_o      <= 1'b0;
            sdio_t      <= 1'b1;
            spi_wr_stb  <= 1'b0;
            spi_wr_addr <= '0;
            spi_wr_data <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            armed       <= armed_n;
            bitcnt      <= bitcnt_n;
            shift_rx    <= shift_rx_n;
            addr        <= addr_n;
            shift_tx    <= shift_tx_n;
            sdio_o      <= sdio_o_n;
            sdio_t      <= sdio_t_n;
            spi_wr_stb  <= stb_n;
            spi_wr_addr <= wr_addr_n;
            spi_wr_data <= wr_data_n;
            frame_done  <= done_n;
            frame_err   <= err_n;
        end
    end

    // SPI write is applied after the host write so it wins on a same-address clash
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
            if (host_we) regs[host_addr] <= host_wdata;
            if (reg_we) regs[addr[AW-1:0]] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_spi3w_target.sv
// Directed bench for spi3w_target with a frame-level register model.
module tb_spi3w_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_in = 1'b0;
    logic       csn_in = 1'b1;
    logic       sdio_i, sdio_o, sdio_t;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wdata = 8'h00;
    logic [7:0] host_rdata;
    logic       spi_wr_stb;
    logic [6:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    logic       frame_done, frame_err;

    logic m_oe = 1'b1;
    logic m_out = 1'b1;

    // pad with pull-up: target wins when it drives, else the master's value
    assign sdio_i = sdio_t ? (m_oe ? m_out : 1'b1) : sdio_o;

    spi3w_target dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .csn_in(csn_in),
        .sdio_i(sdio_i), .sdio_o(sdio_o), .sdio_t(sdio_t),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .spi_wr_stb(spi_wr_stb),
        .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_stb = 0, n_done = 0, n_err = 0;
    int csn_hi = 0;
    bit busy = 1'b1;

    logic [7:0] mregs [16];
    logic [6:0] m_wr_addr;
    logic [7:0] m_wr_data;
    logic [7:0] rdv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (spi_wr_stb === 1'b1) n_stb++;
        if (frame_done === 1'b1) n_done++;
        if (frame_err === 1'b1) n_err++;
        csn_hi = csn_in ? csn_hi + 1 : 0;
        if (!busy && !reset) begin
            check("host_rdata", 32'(host_rdata), 32'(mregs[host_addr]));
            check("spi_wr_addr", 32'(spi_wr_addr), 32'(m_wr_addr));
            check("spi_wr_data", 32'(spi_wr_data), 32'(m_wr_data));
        end
        if (!reset && csn_hi >= 4) check("sdio_t_csn_high", 32'(sdio_t), 32'd1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(posedge clk);
        mregs[a] = d;
        #3 host_we = 1'b0;
    endtask

    // hbit: rise index where a host write lands on the SPI commit clock; rbit: reset
    task automatic spi_frame(
        input bit rd, input logic [6:0] a, input logic [7:0] wd, input int nbits,
        input int hbit, input logic [3:0] ha, input logic [7:0] hd,
        input int rbit, output logic [7:0] rdata);
        logic [15:0] tx;
        logic [7:0]  snap;
        int s0, d0, e0;
        bit inr, full, was_rst;
        tx = {rd, a, wd};
        inr = (a < 7'd16);
        full = (nbits == 16);
        was_rst = 1'b0;
        snap = inr ? mregs[a[3:0]] : 8'h00;
        rdata = 8'h00;
        busy = 1'b1;
        s0 = n_stb; d0 = n_done; e0 = n_err;
        m_oe = 1'b1;
        m_out = tx[15];
        csn_in = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            sclk_in = 1'b1;
            if (rd && i >= 8) rdata[15-i] = sdio_i;
            if (i == hbit) begin
                repeat (2) @(posedge clk);
                #1;
                host_we = 1'b1; host_addr = ha; host_wdata = hd;
                @(posedge clk);
                #1 host_we = 1'b0;
                mregs[ha] = hd;
            end else begin
                repeat (3) @(posedge clk);
                #1;
            end
            if (i == rbit) begin
                reset = 1'b1;
                was_rst = 1'b1;
                for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
                m_wr_addr = '0;
                m_wr_data = '0;
            end else if (was_rst) begin
                check("sdio_t_after_rst", 32'(sdio_t), 32'd1);
            end
            if (rd && !was_rst && (i == 7 || i == 15))
                check("sdio_t_turn", 32'(sdio_t), 32'd1);
            repeat (5) @(posedge clk);
            #2;
            sclk_in = 1'b0;
            if (i + 1 < nbits) begin
                m_oe = (i + 1 < 8) || !rd;
                m_out = tx[14-i];
            end
            repeat (3) @(posedge clk);
            #1;
            if (i == rbit) begin
                reset = 1'b0;
                check("rst_sdio_t", 32'(sdio_t), 32'd1);
                check("rst_sdio_o", 32'(sdio_o), 32'd0);
                check("rst_wr_addr", 32'(spi_wr_addr), 32'd0);
                check("rst_wr_data", 32'(spi_wr_data), 32'd0);
                check("rst_host_rdata", 32'(host_rdata), 32'd0);
            end else if (rd && !was_rst && i >= 7 && i < 15) begin
                check("sdio_t_drive", 32'(sdio_t), 32'd0);
                check("sdio_o_bit", 32'(sdio_o), 32'(snap[14-i]));
            end
            repeat (5) @(posedge clk);
            #2;
        end
        csn_in = 1'b1;
        m_oe = 1'b1;
        m_out = 1'b1;
        if (!full) begin
            repeat (3) @(posedge clk);
            #1 check("abort_release", 32'(sdio_t), 32'd1);
        end
        wait_clk(10);
        check("wr_stb_count", 32'(n_stb - s0), 32'(!was_rst && full && inr && !rd));
        check("done_count", 32'(n_done - d0), 32'(!was_rst && full && inr));
        check("err_count", 32'(n_err - e0), 32'(!was_rst && (!full || !inr)));
        if (rd && full && !was_rst) check("read_data", 32'(rdata), 32'(snap));
        if (!was_rst && full && inr && !rd) begin
            mregs[a[3:0]] = wd;
            m_wr_addr = a;
            m_wr_data = wd;
        end
        busy = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) mregs[k] = 8'h00;
        m_wr_addr = '0;
        m_wr_data = '0;
        wait_clk(4);
        reset = 1'b0;
        wait_clk(1);
        check("reset_sdio_t", 32'(sdio_t), 32'd1);
        check("reset_sdio_o", 32'(sdio_o), 32'd0);
        check("reset_stb", 32'({spi_wr_stb, frame_done, frame_err}), 32'd0);
        check("reset_wr_addr", 32'(spi_wr_addr), 32'd0);
        check("reset_wr_data", 32'(spi_wr_data), 32'd0);
        check("reset_host_rdata", 32'(host_rdata), 32'd0);
        busy = 1'b0;
        wait_clk(5);

        spi_frame(1'b0, 7'h03, 8'hA5, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_wr_addr", 32'(spi_wr_addr), 32'h03);
        check("lit_wr_data", 32'(spi_wr_data), 32'hA5);
        spi_frame(1'b1, 7'h03, 8'h00, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_read_03", 32'(rdv), 32'hA5);
        host_addr = 4'd3;
        wait_clk(1);
        check("lit_host_03", 32'(host_rdata), 32'hA5);

        host_write(4'd0, 8'h81);
        spi_frame(1'b1, 7'h00, 8'h00, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_read_00", 32'(rdv), 32'h81);

        spi_frame(1'b0, 7'h20, 8'h5A, 16, -1, 4'd0, 8'h00, -1, rdv);
        spi_frame(1'b1, 7'h20, 8'h00, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_read_oor", 32'(rdv), 32'h00);

        host_write(4'd5, 8'h3C);
        spi_frame(1'b1, 7'h05, 8'h00, 11, -1, 4'd0, 8'h00, -1, rdv);
        spi_frame(1'b1, 7'h05, 8'h00, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_read_05", 32'(rdv), 32'h3C);

        spi_frame(1'b0, 7'h02, 8'h22, 16, 15, 4'd2, 8'h11, -1, rdv);
        host_addr = 4'd2;
        wait_clk(1);
        check("lit_collide_same", 32'(host_rdata), 32'h22);

        spi_frame(1'b0, 7'h06, 8'h66, 16, 15, 4'd9, 8'h99, -1, rdv);
        host_addr = 4'd9;
        wait_clk(1);
        check("lit_collide_host", 32'(host_rdata), 32'h99);

        spi_frame(1'b1, 7'h03, 8'h00, 16, 9, 4'd3, 8'h77, -1, rdv);
        check("lit_snapshot", 32'(rdv), 32'hA5);

        spi_frame(1'b0, 7'h07, 8'hEE, 16, -1, 4'd0, 8'h00, 12, rdv);
        spi_frame(1'b0, 7'h01, 8'h42, 16, -1, 4'd0, 8'h00, -1, rdv);
        spi_frame(1'b1, 7'h01, 8'h00, 16, -1, 4'd0, 8'h00, -1, rdv);
        check("lit_after_reset", 32'(rdv), 32'h42);

        for (int k = 0; k < 16; k++) begin
            host_addr = 4'(k);
            wait_clk(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
